// File: rtl/temp_regulation_ctrl.sv
// Temperature regulation sequencer: periodic sampling, classification, debounce/hysteresis, CRIT alarm handling.
// Optional min/max tracking is built when TEMP_REGULATION_CTRL_MINMAX_EN is defined.
module temp_regulation_ctrl #(
  parameter int SAMPLE_DIV = 100,
  parameter int DEBOUNCE   = 4,
  parameter int COLD_TH    = 90,
  parameter int HOT_TH     = 100,
  parameter int CRIT_TH    = 110,
  parameter int HYST       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] temperature,
  input  logic       temp_valid,
  input  logic       alarm_ack,
  output logic       sample_strobe,
  output logic [1:0] state,
  output logic       fan_on,
  output logic       heater_on,
  output logic       alarm,
  output logic       shutdown_req,
  output logic [7:0] crit_count,
  output logic [7:0] temp_min,
  output logic [7:0] temp_max
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_COLD   = 2'd1,
    ST_HOT    = 2'd2,
    ST_CRIT   = 2'd3
  } state_t;

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [7:0] COLD_TH8 = 8'(COLD_TH);
  localparam logic [7:0] HOT_TH8  = 8'(HOT_TH);
  localparam logic [7:0] CRIT_TH8 = 8'(CRIT_TH);

  // HOT exit threshold is formed at 9 bits so a large HYST clamps to zero instead of wrapping.
  localparam int         HOT_EXIT_I = (HOT_TH >= HYST) ? (HOT_TH - HYST) : 0;
  localparam logic [8:0] HOT_EXIT   = 9'(HOT_EXIT_I);

  logic [DIV_W-1:0] div_q, div_d;
  state_t           state_q, state_d;
  state_t           cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             alarm_q, alarm_d;
  logic [7:0]       crit_count_q, crit_count_d;

  logic             strobe;
  logic             sample;
  state_t           raw_class;
  state_t           eff_class;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             crit_entry;
  logic             crit_exit;

  assign strobe = (div_q == DIV_LAST);
  assign sample = strobe & temp_valid;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      state_q      <= ST_NORMAL;
      cand_q       <= ST_NORMAL;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      alarm_q      <= 1'b0;
      crit_count_q <= 8'h00;
    end else begin
      div_q        <= div_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      alarm_q      <= alarm_d;
      crit_count_q <= crit_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Classification with HOT-exit hysteresis
  // ---------------------------------------------------------------------------
  always_comb begin
    if (temperature > CRIT_TH8) begin
      raw_class = ST_CRIT;
    end else if (temperature > HOT_TH8) begin
      raw_class = ST_HOT;
    end else if (temperature < COLD_TH8) begin
      raw_class = ST_COLD;
    end else begin
      raw_class = ST_NORMAL;
    end

    eff_class = raw_class;
    if (state_q == ST_HOT && raw_class == ST_NORMAL && {1'b0, temperature} >= HOT_EXIT) begin
      eff_class = ST_HOT;
    end
  end

  assign cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d        = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    cnt_next     = cnt_q;
    crit_entry   = 1'b0;
    crit_exit    = 1'b0;

    if (sample) begin
      if (state_q == ST_CRIT) begin
        // Count saturates so an acknowledgement arriving late releases on the next clean sample.
        if (raw_class == ST_CRIT) begin
          cnt_d = '0;
        end else if (cnt_inc == CNT_MAX && ack_q) begin
          state_d   = raw_class;
          cnt_d     = '0;
          crit_exit = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end else if (raw_class == ST_CRIT) begin
        state_d    = ST_CRIT;
        cnt_d      = '0;
        crit_entry = 1'b1;
      end else if (eff_class == state_q) begin
        cnt_d = '0;
      end else begin
        if (eff_class == cand_q) begin
          cnt_next = cnt_inc;
        end else begin
          cand_d   = eff_class;
          cnt_next = CNT_ONE;
        end
        if (cnt_next >= CNT_MAX) begin
          state_d = eff_class;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_next;
        end
      end
    end

    ack_d   = ack_q;
    alarm_d = alarm_q;
    if (crit_entry) begin
      alarm_d = 1'b1;
      ack_d   = 1'b0;
    end else if (crit_exit) begin
      ack_d = 1'b0;
    end else if (alarm_ack) begin
      if (state_q == ST_CRIT) begin
        ack_d = 1'b1;
      end else begin
        alarm_d = 1'b0;
      end
    end

    crit_count_d = crit_count_q;
    if (crit_entry && crit_count_q != 8'hFF) begin
      crit_count_d = crit_count_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional min/max tracking
  // ---------------------------------------------------------------------------
`ifdef TEMP_REGULATION_CTRL_MINMAX_EN
  logic [7:0] min_q, min_d;
  logic [7:0] max_q, max_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= 8'hFF;
      max_q <= 8'h00;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (sample) begin
      if (temperature < min_q) min_d = temperature;
      if (temperature > max_q) max_d = temperature;
    end
  end
`else
  logic [7:0] min_q;
  logic [7:0] max_q;

  assign min_q = 8'h00;
  assign max_q = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Output decode from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    sample_strobe = strobe;
    state         = state_q;
    fan_on        = (state_q == ST_HOT) || (state_q == ST_CRIT);
    heater_on     = (state_q == ST_COLD);
    shutdown_req  = (state_q == ST_CRIT);
    alarm         = alarm_q;
    crit_count    = crit_count_q;
    temp_min      = min_q;
    temp_max      = max_q;
  end

endmodule

// File: tb/tb_temp_regulation_ctrl.sv
// Directed bench for temp_regulation_ctrl (SAMPLE_DIV=4, DEBOUNCE=3); min/max expectations follow
// TEMP_REGULATION_CTRL_MINMAX_EN.
module tb_temp_regulation_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] temperature;
  logic       temp_valid;
  logic       alarm_ack;
  logic       sample_strobe;
  logic [1:0] state;
  logic       fan_on;
  logic       heater_on;
  logic       alarm;
  logic       shutdown_req;
  logic [7:0] crit_count;
  logic [7:0] temp_min;
  logic [7:0] temp_max;

  int total = 0;
  int bad   = 0;

`ifdef TEMP_REGULATION_CTRL_MINMAX_EN
  localparam logic [7:0] MIN_RST = 8'hFF;
`else
  localparam logic [7:0] MIN_RST = 8'h00;
`endif

  temp_regulation_ctrl #(
    .SAMPLE_DIV(4),
    .DEBOUNCE  (3),
    .COLD_TH   (90),
    .HOT_TH    (100),
    .CRIT_TH   (110),
    .HYST      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .temperature  (temperature),
    .temp_valid   (temp_valid),
    .alarm_ack    (alarm_ack),
    .sample_strobe(sample_strobe),
    .state        (state),
    .fan_on       (fan_on),
    .heater_on    (heater_on),
    .alarm        (alarm),
    .shutdown_req (shutdown_req),
    .crit_count   (crit_count),
    .temp_min     (temp_min),
    .temp_max     (temp_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst       = 1'b1;
    alarm_ack = 1'b0;
    temp_valid = 1'b1;
    temperature = 8'd95;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Present one reading, wait for its strobe, return 1ns after the edge that ends the strobe cycle.
  task automatic do_sample(input logic [7:0] t, input logic v, input logic ack);
    int guard;
    temperature = t;
    temp_valid  = v;
    guard = 0;
    while (sample_strobe !== 1'b1 && guard < 12) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (sample_strobe !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL strobe_timeout got=%b want=1", sample_strobe);
    end
    alarm_ack = ack;
    @(posedge clk);
    #1;
    alarm_ack = 1'b0;
    $display("sample t=%0d v=%0d ack=%0d -> state=%0d alarm=%0d crit_count=%0d",
             t, v, ack, state, alarm, crit_count);
  endtask

  task automatic pulse_ack();
    alarm_ack = 1'b1;
    @(posedge clk);
    #1;
    alarm_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; temperature = 8'd95; temp_valid = 1'b1; alarm_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
    total++; if ({sample_strobe, fan_on, heater_on, alarm, shutdown_req} !== 5'b0) begin
      bad++; $display("FAIL rst_flags got=%b want=00000", {sample_strobe, fan_on, heater_on, alarm, shutdown_req}); end
    total++; if (crit_count !== 8'd0) begin bad++; $display("FAIL rst_crit_count got=%0d want=0", crit_count); end
    total++; if (temp_min !== MIN_RST) begin bad++; $display("FAIL rst_temp_min got=%h want=%h", temp_min, MIN_RST); end
    total++; if (temp_max !== 8'h00) begin bad++; $display("FAIL rst_temp_max got=%h want=00", temp_max); end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (sample_strobe !== ((i % 4) == 3)) begin
        bad++; $display("FAIL strobe_cycle%0d got=%b want=%b", i, sample_strobe, ((i % 4) == 3));
      end
      @(posedge clk);
      #1;
    end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d want=0", state); end
    total++; if ({fan_on, heater_on, alarm, shutdown_req} !== 4'b0) begin
      bad++; $display("FAIL idle_flags got=%b want=0000", {fan_on, heater_on, alarm, shutdown_req}); end
  endtask

  task automatic test_cold();
    apply_reset();
    do_sample(8'd85, 1'b1, 1'b0);
    do_sample(8'd85, 1'b1, 1'b0);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL cold_two_state got=%0d want=0", state); end
    do_sample(8'd95, 1'b1, 1'b0);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL cold_abort_state got=%0d want=0", state); end
    do_sample(8'd85, 1'b1, 1'b0);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL cold_restart_state got=%0d want=0", state); end
    do_sample(8'd85, 1'b1, 1'b0);
    do_sample(8'd85, 1'b1, 1'b0);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL cold_state got=%0d want=1", state); end
    total++; if (heater_on !== 1'b1 || fan_on !== 1'b0) begin
      bad++; $display("FAIL cold_outputs got=heater%b fan%b want=heater1 fan0", heater_on, fan_on); end
  endtask

  task automatic test_hot_hysteresis();
    apply_reset();
    do_sample(8'd105, 1'b1, 1'b0);
    do_sample(8'd105, 1'b1, 1'b0);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL hot_two_state got=%0d want=0", state); end
    do_sample(8'd105, 1'b1, 1'b0);
    total++; if (state !== 2'd2 || fan_on !== 1'b1) begin
      bad++; $display("FAIL hot_entry got=state%0d fan%b want=state2 fan1", state, fan_on); end
    for (int i = 0; i < 5; i++) do_sample(8'd99, 1'b1, 1'b0);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL hot_hyst_state got=%0d want=2", state); end
    do_sample(8'd97, 1'b1, 1'b0);
    do_sample(8'd97, 1'b1, 1'b0);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL hot_exit_early got=%0d want=2", state); end
    do_sample(8'd97, 1'b1, 1'b0);
    total++; if (state !== 2'd0 || fan_on !== 1'b0) begin
      bad++; $display("FAIL hot_exit got=state%0d fan%b want=state0 fan0", state, fan_on); end
  endtask

  task automatic test_crit();
    apply_reset();
    do_sample(8'd120, 1'b1, 1'b0);
    total++; if (state !== 2'd3) begin bad++; $display("FAIL crit_entry_state got=%0d want=3", state); end
    total++; if ({alarm, shutdown_req, fan_on} !== 3'b111) begin
      bad++; $display("FAIL crit_entry_flags got=%b want=111", {alarm, shutdown_req, fan_on}); end
    total++; if (crit_count !== 8'd1) begin bad++; $display("FAIL crit_count1 got=%0d want=1", crit_count); end
    for (int i = 0; i < 3; i++) do_sample(8'd95, 1'b1, 1'b0);
    total++; if (state !== 2'd3) begin bad++; $display("FAIL crit_noack_hold got=%0d want=3", state); end
    pulse_ack();
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL crit_ack_alarm got=%b want=1", alarm); end
    for (int i = 0; i < 3; i++) do_sample(8'd95, 1'b1, 1'b0);
    total++; if (state !== 2'd0 || shutdown_req !== 1'b0) begin
      bad++; $display("FAIL crit_exit got=state%0d shutdown%b want=state0 shutdown0", state, shutdown_req); end
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL crit_exit_alarm got=%b want=1", alarm); end
    pulse_ack();
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL alarm_clear got=%b want=0", alarm); end
    // Entry and ack in the same cycle: the ack must be discarded.
    do_sample(8'd120, 1'b1, 1'b1);
    total++; if (state !== 2'd3 || alarm !== 1'b1) begin
      bad++; $display("FAIL entry_ack_same got=state%0d alarm%b want=state3 alarm1", state, alarm); end
    total++; if (crit_count !== 8'd2) begin bad++; $display("FAIL crit_count2 got=%0d want=2", crit_count); end
    for (int i = 0; i < 3; i++) do_sample(8'd95, 1'b1, 1'b0);
    total++; if (state !== 2'd3) begin bad++; $display("FAIL entry_ack_discard got=%0d want=3", state); end
  endtask

  task automatic test_valid_gap();
    apply_reset();
    do_sample(8'd85, 1'b1, 1'b0);
    do_sample(8'd85, 1'b0, 1'b0);
    do_sample(8'd85, 1'b1, 1'b0);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL gap_hold got=%0d want=0", state); end
    do_sample(8'd85, 1'b1, 1'b0);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL gap_change got=%0d want=1", state); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_sample(8'd120, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL midrst_state got=%0d want=0", state); end
    total++; if ({sample_strobe, fan_on, heater_on, alarm, shutdown_req} !== 5'b0) begin
      bad++; $display("FAIL midrst_flags got=%b want=00000", {sample_strobe, fan_on, heater_on, alarm, shutdown_req}); end
    total++; if (crit_count !== 8'd0 || temp_max !== 8'h00 || temp_min !== MIN_RST) begin
      bad++; $display("FAIL midrst_regs got=cc%0d max%h min%h want=cc0 max00 min%h", crit_count, temp_max, temp_min, MIN_RST); end
    rst = 1'b0;
    do_sample(8'd85, 1'b1, 1'b0);
    do_sample(8'd85, 1'b1, 1'b0);
    apply_reset();
    do_sample(8'd85, 1'b1, 1'b0);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL midrst_debounce got=%0d want=0", state); end
    do_sample(8'd85, 1'b1, 1'b0);
    do_sample(8'd85, 1'b1, 1'b0);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL midrst_recover got=%0d want=1", state); end
  endtask

  task automatic test_minmax();
    logic [7:0] exp_min;
    logic [7:0] exp_max;
    apply_reset();
    do_sample(8'd95, 1'b1, 1'b0);
`ifdef TEMP_REGULATION_CTRL_MINMAX_EN
    exp_min = 8'd95; exp_max = 8'd95;
`else
    exp_min = 8'd0; exp_max = 8'd0;
`endif
    total++; if (temp_min !== exp_min || temp_max !== exp_max) begin
      bad++; $display("FAIL minmax_first got=min%0d max%0d want=min%0d max%0d", temp_min, temp_max, exp_min, exp_max); end
    do_sample(8'd120, 1'b1, 1'b0);
    do_sample(8'd50, 1'b0, 1'b0);
    do_sample(8'd85, 1'b1, 1'b0);
`ifdef TEMP_REGULATION_CTRL_MINMAX_EN
    exp_min = 8'd85; exp_max = 8'd120;
`endif
    total++; if (temp_min !== exp_min || temp_max !== exp_max) begin
      bad++; $display("FAIL minmax_final got=min%0d max%0d want=min%0d max%0d", temp_min, temp_max, exp_min, exp_max); end
  endtask

  task automatic test_crit_saturate();
    apply_reset();
    for (int k = 1; k <= 256; k++) begin
      do_sample(8'd120, 1'b1, 1'b0);
      if (k == 255) begin
        total++; if (crit_count !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", crit_count); end
      end
      if (k == 256) begin
        total++; if (crit_count !== 8'd255) begin bad++; $display("FAIL sat_256 got=%0d want=255", crit_count); end
      end
      pulse_ack();
      for (int i = 0; i < 3; i++) do_sample(8'd95, 1'b1, 1'b0);
    end
    total++; if (state !== 2'd0 || alarm !== 1'b1) begin
      bad++; $display("FAIL sat_final got=state%0d alarm%b want=state0 alarm1", state, alarm); end
  endtask

  initial begin
    rst = 1'b1;
    temperature = 8'd95;
    temp_valid = 1'b1;
    alarm_ack = 1'b0;
    test_reset();
    test_cold();
    test_hot_hysteresis();
    test_crit();
    test_valid_gap();
    test_reset_mid();
    test_minmax();
    test_crit_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
